// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use hazard / control-flush unit.
package hazard_pkg;

    // Controller state: IDLE passes or single-cycle stalls, STALL holds the front end.
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Load-use hazard decision from pre-computed register-address matches.
    function automatic logic hazard_fn(
        input logic mem_read,
        input logic rs1_used,
        input logic rs1_hit,
        input logic rs2_used,
        input logic rs2_hit,
        input logic rd_is_x0,
        input logic ignore_x0
    );
        return mem_read & ((rs1_used & rs1_hit) | (rs2_used & rs2_hit)) & ~(ignore_x0 & rd_is_x0);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_cnt.sv
// stall_down_counter: loadable down-counter that saturates at zero.
module stall_down_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero so a long busy wait never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall and branch-flush control for the ID/EX boundary.
// Optional stall performance counter is built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter bit IGNORE_X0         = 1'b1,
    parameter int PERF_CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              branch_taken_ex,
    input  logic              dmem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              stall_active
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_count
`endif
);

    localparam int CNT_W = $clog2(LOAD_STALL_CYCLES + 1);

    if (LOAD_STALL_CYCLES < 1) begin : g_param_chk
        $error("hazard_stall_ctrl: LOAD_STALL_CYCLES must be >= 1");
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_le1;
    logic             hazard;
    logic             need_stall_state;
    logic             enter_stall;

    assign hazard = hazard_fn(mem_read_ex, rs1_used_id, (rd_ex == rs1_id),
                              rs2_used_id, (rd_ex == rs2_id), (rd_ex == '0), IGNORE_X0);

    // A single-cycle stall with memory ready is finished within the hazard cycle itself.
    assign need_stall_state = (LOAD_STALL_CYCLES > 1) || dmem_busy;
    assign enter_stall      = (state_q == IDLE) && !branch_taken_ex && hazard && need_stall_state;
    assign cnt_le1          = cnt_zero || (cnt == CNT_W'(1));

    stall_down_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (enter_stall),
        .load_val_i (CNT_W'(LOAD_STALL_CYCLES - 1)),
        .dec_i      (state_q == STALL),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // State register: enter on hazard, leave when the count is spent and memory is ready, or on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enter_stall) state_q <= STALL;
                STALL:   if (branch_taken_ex || (cnt_le1 && !dmem_busy)) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pipeline control: redirect flush always wins, then stall, then free-running.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        stall_active = (state_q == STALL);
        if (branch_taken_ex) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if ((state_q == STALL) || hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] stall_count_q;

    // Count frozen cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (!pc_write && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;
`else
    // PERF_CNT_W has no effect without the counter.
    localparam int unused_perf_cnt_w = PERF_CNT_W;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (LOAD_STALL_CYCLES = 1, 2, 3) share stimulus
// and are compared each cycle against a freeze-length reference model.
module tb_hazard_stall_ctrl;

    localparam int N  = 3;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read_ex;
    logic [AW-1:0] rd_ex, rs1_id, rs2_id;
    logic          rs1_used_id, rs2_used_id, branch_taken_ex, dmem_busy;

    logic pc_write     [N];
    logic if_id_write  [N];
    logic id_ex_bubble [N];
    logic if_id_flush  [N];
    logic stall_active [N];
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_count [N];
    int          perf_m [N];
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int el  [N];          // cycles already frozen for the current hazard; -1 = not in a freeze beyond its first cycle
    logic [4:0] exp_q [N];
    string phase = "reset";

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        hazard_stall_ctrl #(
            .REG_AW(AW), .LOAD_STALL_CYCLES(k + 1), .IGNORE_X0(1'b1), .PERF_CNT_W(16)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .mem_read_ex     (mem_read_ex),
            .rd_ex           (rd_ex),
            .rs1_id          (rs1_id),
            .rs2_id          (rs2_id),
            .rs1_used_id     (rs1_used_id),
            .rs2_used_id     (rs2_used_id),
            .branch_taken_ex (branch_taken_ex),
            .dmem_busy       (dmem_busy),
            .pc_write        (pc_write[k]),
            .if_id_write     (if_id_write[k]),
            .id_ex_bubble    (id_ex_bubble[k]),
            .if_id_flush     (if_id_flush[k]),
            .stall_active    (stall_active[k])
`ifdef HAZARD_PERF_EN
            ,
            .stall_count     (stall_count[k])
`endif
        );
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic hz();
        return mem_read_ex && rd_ex != 0 &&
               ((rs1_used_id && rd_ex == rs1_id) || (rs2_used_id && rd_ex == rs2_id));
    endfunction

    // Expected {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall_active}.
    function automatic logic [4:0] exp_out(int k);
        if (el[k] >= 1) return branch_taken_ex ? 5'b11111 : 5'b00101;
        if (branch_taken_ex) return 5'b11110;
        if (hz()) return 5'b00100;
        return 5'b11000;
    endfunction

    task automatic drive(input logic mr, input int rd, input int r1, input int r2,
                         input logic u1, input logic u2, input logic br, input logic busy);
        mem_read_ex = mr; rd_ex = AW'(rd); rs1_id = AW'(r1); rs2_id = AW'(r2);
        rs1_used_id = u1; rs2_used_id = u2; branch_taken_ex = br; dmem_busy = busy;
    endtask

    task automatic quiet();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check outputs of the current cycle, then advance the model over the next rising edge.
    task automatic step();
        #1;
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                el[k] = -1;
`ifdef HAZARD_PERF_EN
                perf_m[k] = 0;
`endif
            end
            exp_q[k] = exp_out(k);
            chk($sformatf("L%0d_%s", k + 1, phase),
                16'({pc_write[k], if_id_write[k], id_ex_bubble[k], if_id_flush[k], stall_active[k]}),
                16'(exp_q[k]));
`ifdef HAZARD_PERF_EN
            chk($sformatf("L%0d_%s_cnt", k + 1, phase), stall_count[k], 16'(perf_m[k]));
`endif
        end
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
`ifdef HAZARD_PERF_EN
                if (!exp_q[k][4] && perf_m[k] < 65535) perf_m[k]++;
`endif
                if (el[k] >= 1) begin
                    if (branch_taken_ex) el[k] = -1;
                    else if (el[k] + 1 < k + 1 || dmem_busy) el[k]++;
                    else el[k] = -1;
                end else if (!branch_taken_ex && hz() && (1 < k + 1 || dmem_busy)) begin
                    el[k] = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) el[k] = -1;
        rst_n = 1'b0;
        quiet();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        phase = "idle";
        idle(2);

        // lw x5 followed by a reader of x5
        phase = "lw_rs1";
        drive(1, 5, 5, 0, 1, 0, 0, 0); step();
        idle(4);

        // x0 destination and unused rs2 never stall
        phase = "x0";
        drive(1, 0, 0, 0, 1, 1, 0, 0); step();
        phase = "rs2_unused";
        drive(1, 7, 3, 7, 1, 0, 0, 0); step();
        phase = "rs2_used";
        drive(1, 7, 3, 7, 0, 1, 0, 0); step();
        idle(4);

        // memory busy for the hazard cycle plus three more
        phase = "busy";
        drive(1, 9, 9, 0, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1); step(); step(); step();
        idle(5);

        // redirect while stalled, and redirect together with a hazard in IDLE
        phase = "br_stall";
        drive(1, 4, 4, 4, 1, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 1, 0); step();
        idle(3);
        phase = "br_hazard";
        drive(1, 4, 4, 4, 1, 1, 1, 0); step();
        idle(3);

        // reset in the middle of a long busy stall
        phase = "rst_mid";
        drive(1, 6, 0, 6, 0, 1, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        quiet();
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(2);

        // randomized traffic with occasional asynchronous resets
        phase = "rand";
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
